enc16_4_queue: RTL and testbench
================================

Name: enc16_4_queue

Overview:
- Sequential 16-to-4 encoder; the inverse of the team's 4-to-16 decoder.
- Latches request events on 16 one-hot/multi-hot lines into a pending register.
- Emits one 4-bit index at a time over a Valid/Ready handshake, clearing each bit as it is issued.
- Sits between event sources (buttons, decoder-driven peripherals) and a consumer that needs a binary code per event.

Parameters:
- RR, 0, arbitration mode: 0 = fixed priority (lowest index wins); 1 = round-robin (search starts at last issued index + 1, wraps 15 -> 0).
- N, 16, number of request lines; fixed at 16, present for documentation only. Any other value is unsupported.

Ports:
- Clock  input  1  single rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Enable  input  1  request capture enable; W ignored when 0
- W  input  [0:15]  request lines; W[i] high for a cycle = event for code i
- Ready  input  1  consumer accepts Y this cycle when Valid=1
- Y  output  [3:0]  registered index of issued request
- Valid  output  1  Y holds an unaccepted index
- Pending  output  [0:15]  registered pending-request vector
- Overrun  output  1  one-cycle pulse: a request hit an already-pending bit

Behaviour:
- Reset (sampled at rising edge while Reset=1):
  - Y=4'd0, Valid=0, Pending=0, Overrun=0, round-robin pointer=15 (first search starts at index 0).
  - Reset overrides every other input, including mid-handshake; an unaccepted Y is discarded.
- Capture, every edge:
  - Pending_next = (Pending & ~clr) | (Enable ? W : 0), where clr is the one-hot of the index loaded this edge (zero if none).
  - Set wins over clear: W[i]=1 in the same cycle bit i is issued leaves bit i pending, which counts as a new event.
- Overrun = registered OR over i of (Enable & W[i] & Pending[i] & ~clr[i]).
  - Duplicates merge into one pending bit and are reported, not counted.
- Output register, two states:
  - EMPTY (Valid=0) -> FULL: at an edge where Pending != 0, load Y = select(Pending), Valid=1, clear that bit.
  - FULL, Ready=1, Pending != 0: reload Y = select(Pending) in the same edge (back-to-back, one index per cycle), stay FULL.
  - FULL, Ready=1, Pending == 0: Valid=0 -> EMPTY.
  - FULL, Ready=0: Y, Valid held stable; Pending still captures new W.
- Selection uses the registered Pending only, never W directly.
  - Latency: W[i] at edge t -> Pending[i]=1 after t -> Y=i, Valid=1 after t+1 (if output free and i wins).
- Ready while Valid=0 is ignored.
- RR=0: lowest set index wins.
- RR=1: first set index searching upward from pointer+1 mod 16; pointer updates to each loaded index.
- Enable=0 blocks capture only; already-pending bits are still issued.
- Y width rule: index 0..15 encoded in 4 unsigned bits; no out-of-range codes possible.

Decomposition:
- Package enc_pkg:
  - localparam N_REQ=16, IDX_W=4.
  - State encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module prio_enc16_4:
  - Combinational; inputs vector[0:15] and start[3:0], outputs idx[3:0] and any.
  - Rotated priority search; RR=0 ties start to 0.
  - Instantiated once.

Test Plan:
- Reset with Pending nonzero, Valid=1 -> next cycle Y=0, Valid=0, Pending=0, Overrun=0.
- RR=0, Enable=1, W=16'h8001 (bits 0 and 15) one cycle, Ready=1 -> Y=0 Valid=1 at t+2, Y=15 at t+3, Valid=0 at t+4, Pending=0.
- RR=0, W bit 5 then Ready=0 for 4 cycles -> Y=5, Valid=1 held stable. Bit 2 arriving meanwhile stays pending; after Ready=1, Y=2 next cycle.
- Enable=1, W bit 7 on two consecutive cycles before issue -> Overrun pulses once, exactly one Y=7 issued. Same test with Enable=0 -> no capture, no Overrun.
- RR=1, W=16'hFFFF held with Enable=1 and Ready=1 -> Y cycles 0,1,...,15,0,... with no index repeated before all 16 issued. RR=0 same stimulus -> Y=0 every cycle (set-wins rule).
- W bit 3 in the same cycle bit 3 is loaded into Y -> Pending[3] remains 1, second Y=3 issued after acceptance, Overrun=0.

Source files
------------

// File: rtl/enc16_4_queue_pkg.sv
// Shared definitions for the 16-to-4 queued encoder.
//   N_REQ / IDX_W : request-line count and index width
//   state_e       : output-register state (EMPTY = no index held, FULL = Y valid)
//   onehot()      : index -> one-hot request vector (bit 0 is the leftmost bit)
package enc_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic [0:N_REQ-1] onehot(input logic [IDX_W-1:0] idx);
    logic [0:N_REQ-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/enc16_4_queue_prio.sv
// Rotated priority encoder: returns the first set bit of vector_i found by
// searching upward from start_i, wrapping 15 -> 0.
//   vector_i [0:15] : candidate request bits
//   start_i  [3:0]  : first index examined
//   idx_o    [3:0]  : winning index (0 when none set)
//   any_o           : at least one bit of vector_i is set
module prio_enc16_4
  import enc_pkg::*;
(
  input  logic [0:N_REQ-1] vector_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Linear scan; the 4-bit sum wraps naturally past index 15.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_o && vector_i[start_i + IDX_W'(k)]) begin
        any_o = 1'b1;
        idx_o = start_i + IDX_W'(k);
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/enc16_4_queue.sv
// Sequential 16-to-4 encoder. Request events on W are merged into a pending
// register and issued one index at a time over a Valid/Ready handshake.
//   Clock, Reset   : rising-edge clock, synchronous active-high reset
//   Enable         : gates capture of W (issuing continues regardless)
//   W [0:15]       : request lines, W[i] high = event for index i
//   Ready          : consumer accepts Y when Valid is high
//   Y [3:0], Valid : issued index and its valid flag
//   Pending [0:15] : requests captured but not yet issued
//   Overrun        : one-cycle pulse when a request hit an already-pending bit
// RR selects fixed priority (0, lowest index wins) or round-robin (1).
module enc16_4_queue
  import enc_pkg::*;
#(
  parameter bit RR = 1'b0,
  parameter int N  = 16
)(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [0:N-1]     W,
  input  logic             Ready,
  output logic [IDX_W-1:0] Y,
  output logic             Valid,
  output logic [0:N-1]     Pending,
  output logic             Overrun
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [0:N_REQ-1] pending_q, pending_d;
  logic             overrun_q, overrun_d;

  logic [IDX_W-1:0] start_s;
  logic [IDX_W-1:0] idx_s;
  logic             any_s;
  logic             load_s;
  logic [0:N_REQ-1] clr_s;
  logic [0:N_REQ-1] set_s;

  // Round-robin resumes one past the last issued index; fixed priority always from 0.
  assign start_s = RR ? (ptr_q + 4'd1) : 4'd0;

  prio_enc16_4 u_prio (
    .vector_i (pending_q),
    .start_i  (start_s),
    .idx_o    (idx_s),
    .any_o    (any_s)
  );

  // Next-state, output reload and pending-vector update.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ptr_d   = ptr_q;
    load_s  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (any_s) begin
          load_s  = 1'b1;
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (Ready) begin
          if (any_s) begin
            load_s  = 1'b1;
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load_s) begin
      y_d   = idx_s;
      ptr_d = idx_s;
    end else begin
      y_d   = y_q;
      ptr_d = ptr_q;
    end

    clr_s = load_s ? onehot(idx_s) : '0;
    set_s = Enable ? W : '0;
    // Set is OR'd after the clear, so a same-cycle re-request survives issue.
    pending_d = (pending_q & ~clr_s) | set_s;
    overrun_d = |(set_s & pending_q & ~clr_s);
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_EMPTY;
      y_q       <= 4'd0;
      ptr_q     <= 4'd15;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign Y       = y_q;
  assign Valid   = (state_q == ST_FULL);
  assign Pending = pending_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_enc16_4_queue.sv
module tb_enc16_4_queue;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [0:15] W;
  logic        Ready;

  logic [3:0]  y0, y1;
  logic        valid0, valid1;
  logic [0:15] pend0, pend1;
  logic        ovr0, ovr1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 Clock = ~Clock;

  enc16_4_queue #(.RR(1'b0), .N(16)) dut0 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .W(W), .Ready(Ready),
    .Y(y0), .Valid(valid0), .Pending(pend0), .Overrun(ovr0)
  );

  enc16_4_queue #(.RR(1'b1), .N(16)) dut1 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .W(W), .Ready(Ready),
    .Y(y1), .Valid(valid1), .Pending(pend1), .Overrun(ovr1)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Build a request vector with a single line i set.
  function automatic logic [0:15] bitv(input int i);
    logic [0:15] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    Reset = 1'b1; Enable = 1'b0; W = '0; Ready = 1'b0;
    tick(); tick();
    check("rst_y",   16'(y0),     16'h0);
    check("rst_v",   16'(valid0), 16'h0);
    check("rst_p",   pend0,       16'h0000);
    check("rst_ovr", 16'(ovr0),   16'h0);

    // Reset while Valid=1 and Pending nonzero
    Reset = 1'b0; Enable = 1'b1; W = 16'h8001;
    tick();
    check("pre_p", pend0, 16'h8001);
    W = '0;
    tick();
    check("pre_y", 16'(y0),     16'h0);
    check("pre_v", 16'(valid0), 16'h1);
    check("pre_p2", pend0,      16'h0001);
    Reset = 1'b1;
    tick();
    check("mid_rst_y", 16'(y0),     16'h0);
    check("mid_rst_v", 16'(valid0), 16'h0);
    check("mid_rst_p", pend0,       16'h0000);
    check("mid_rst_o", 16'(ovr0),   16'h0);

    // Bits 0 and 15, Ready=1
    Reset = 1'b0; Ready = 1'b1; W = 16'h8001;
    tick();
    check("t2_p", pend0, 16'h8001);
    check("t2_v", 16'(valid0), 16'h0);
    W = '0;
    tick();
    check("t2_y0",  16'(y0), 16'h0);
    check("t2_v0",  16'(valid0), 16'h1);
    check("t2_y0r", 16'(y1), 16'h0);
    tick();
    check("t2_y15",  16'(y0), 16'hF);
    check("t2_y15r", 16'(y1), 16'hF);
    check("t2_p15",  pend0,   16'h0000);
    tick();
    check("t2_vend", 16'(valid0), 16'h0);
    check("t2_pend", pend0,       16'h0000);

    // Bit 5 held under backpressure, bit 2 queued meanwhile
    Ready = 1'b0; W = bitv(5);
    tick();
    check("t3_p5", pend0, 16'h0400);
    W = '0;
    tick();
    check("t3_y5", 16'(y0), 16'h5);
    check("t3_v5", 16'(valid0), 16'h1);
    W = bitv(2);
    tick();
    check("t3_hold_y", 16'(y0), 16'h5);
    check("t3_p2",     pend0,   16'h2000);
    W = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_y", 16'(y0), 16'h5);
      check("t3_hold_v", 16'(valid0), 16'h1);
      check("t3_hold_p", pend0, 16'h2000);
    end
    Ready = 1'b1;
    tick();
    check("t3_y2", 16'(y0), 16'h2);
    check("t3_v2", 16'(valid0), 16'h1);
    check("t3_p0", pend0, 16'h0000);
    tick();
    check("t3_vend", 16'(valid0), 16'h0);

    // Duplicate request while the output is occupied -> one Overrun pulse
    Ready = 1'b0; W = bitv(1);
    tick();
    W = '0;
    tick();
    check("t4_y1", 16'(y0), 16'h1);
    W = bitv(7);
    tick();
    check("t4_p7",  pend0, 16'h0100);
    check("t4_ov0", 16'(ovr0), 16'h0);
    tick();
    check("t4_ov1", 16'(ovr0), 16'h1);
    check("t4_p7b", pend0, 16'h0100);
    W = '0;
    tick();
    check("t4_ov2", 16'(ovr0), 16'h0);
    Ready = 1'b1;
    tick();
    check("t4_y7", 16'(y0), 16'h7);
    check("t4_v7", 16'(valid0), 16'h1);
    check("t4_pe", pend0, 16'h0000);
    tick();
    check("t4_vend", 16'(valid0), 16'h0);

    // Same with Enable=0: nothing captured
    Enable = 1'b0; W = bitv(7);
    tick();
    check("t4e_p", pend0, 16'h0000);
    check("t4e_o", 16'(ovr0), 16'h0);
    tick();
    check("t4e_p2", pend0, 16'h0000);
    check("t4e_o2", 16'(ovr0), 16'h0);
    W = '0;
    tick();
    check("t4e_v", 16'(valid0), 16'h0);

    // All lines held: RR cycles through every index, fixed priority repeats 0
    Reset = 1'b1;
    tick();
    Reset = 1'b0; Enable = 1'b1; Ready = 1'b1; W = 16'hFFFF;
    tick();
    check("t5_p", pend1, 16'hFFFF);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t5_rr_y",  16'(y1), 16'(k % 16));
      check("t5_rr_v",  16'(valid1), 16'h1);
      check("t5_fix_y", 16'(y0), 16'h0);
    end
    W = '0;

    // Re-request of bit 3 on the edge it is issued
    Reset = 1'b1;
    tick();
    Reset = 1'b0; Ready = 1'b1; W = bitv(3);
    tick();
    check("t6_p", pend0, 16'h1000);
    tick();
    check("t6_y",  16'(y0),    16'h3);
    check("t6_p3", pend0,      16'h1000);
    check("t6_o",  16'(ovr0),  16'h0);
    W = '0;
    tick();
    check("t6_y2", 16'(y0),     16'h3);
    check("t6_v2", 16'(valid0), 16'h1);
    check("t6_p0", pend0,       16'h0000);
    check("t6_o2", 16'(ovr0),   16'h0);
    tick();
    check("t6_vend", 16'(valid0), 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
